// File: rtl/hdmi_tx_lane_sequencer.sv
// Start-up and recovery sequencer for the HDMI TX serializer lanes: qualifies MMCM lock,
// holds the serializers in reset, sends a control-token preamble, then passes encoded video.
module hdmi_tx_lane_sequencer #(
  parameter int         LOCK_FILTER     = 16,
  parameter int         SER_RST_CYCLES  = 256,
  parameter int         PREAMBLE_CYCLES = 1024,
  parameter logic [9:0] CTL_TOKEN       = 10'b1101010100
) (
  input  logic       pclk,
  input  logic       txrst,
  input  logic       mmcm_locked,
  input  logic       tx_en,
  input  logic [9:0] vid_d0,
  input  logic [9:0] vid_d1,
  input  logic [9:0] vid_d2,
  output logic       ser_rst,
  output logic [9:0] lane0_txdata,
  output logic [9:0] lane1_txdata,
  output logic [9:0] lane2_txdata,
  output logic [9:0] clk_txdata,
  output logic       link_up,
  output logic [2:0] state_o
);

  localparam logic [9:0]  CLK_PATTERN   = 10'b1111100000;
  localparam logic [15:0] LOCK_LAST     = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] SER_RST_LAST  = 16'(SER_RST_CYCLES - 1);
  localparam logic [15:0] PREAMBLE_LAST = 16'(PREAMBLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    SER_RST   = 3'd2,
    PREAMBLE  = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_lockCnt;
  logic [15:0] r_cnt;
  logic        r_lockMeta;
  logic        r_lockSync;

  // mmcm_locked comes from the MMCM with no relation to pclk
  always_ff @(posedge pclk or posedge txrst) begin
    if (txrst) begin
      r_lockMeta <= 1'b0;
      r_lockSync <= 1'b0;
    end else begin
      r_lockMeta <= mmcm_locked;
      r_lockSync <= r_lockMeta;
    end
  end

  // Disable beats lock loss, which beats normal phase progression
  always_ff @(posedge pclk or posedge txrst) begin
    if (txrst) begin
      r_state   <= IDLE;
      r_lockCnt <= 16'd0;
      r_cnt     <= 16'd0;
    end else if (r_state != IDLE && !tx_en) begin
      r_state   <= IDLE;
      r_lockCnt <= 16'd0;
      r_cnt     <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_lockCnt <= 16'd0;
          r_cnt     <= 16'd0;
          if (tx_en) r_state <= WAIT_LOCK;
        end
        WAIT_LOCK: begin
          r_cnt <= 16'd0;
          if (!r_lockSync) begin
            r_lockCnt <= 16'd0;
          end else if (r_lockCnt == LOCK_LAST) begin
            r_state   <= SER_RST;
            r_lockCnt <= 16'd0;
          end else begin
            r_lockCnt <= r_lockCnt + 16'd1;
          end
        end
        SER_RST: begin
          if (!r_lockSync) begin
            r_state   <= WAIT_LOCK;
            r_lockCnt <= 16'd0;
            r_cnt     <= 16'd0;
          end else if (r_cnt == SER_RST_LAST) begin
            r_state <= PREAMBLE;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        PREAMBLE: begin
          if (!r_lockSync) begin
            r_state   <= WAIT_LOCK;
            r_lockCnt <= 16'd0;
            r_cnt     <= 16'd0;
          end else if (r_cnt == PREAMBLE_LAST) begin
            r_state <= RUN;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RUN: begin
          if (!r_lockSync) begin
            r_state   <= WAIT_LOCK;
            r_lockCnt <= 16'd0;
            r_cnt     <= 16'd0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_lockCnt <= 16'd0;
          r_cnt     <= 16'd0;
        end
      endcase
    end
  end

  // Outputs follow the state one cycle later; unknown encodings fall into the safe branch
  always_ff @(posedge pclk or posedge txrst) begin
    if (txrst) begin
      ser_rst      <= 1'b1;
      link_up      <= 1'b0;
      lane0_txdata <= CTL_TOKEN;
      lane1_txdata <= CTL_TOKEN;
      lane2_txdata <= CTL_TOKEN;
      clk_txdata   <= 10'b0000000000;
    end else begin
      ser_rst    <= !(r_state == PREAMBLE || r_state == RUN);
      link_up    <= (r_state == RUN);
      clk_txdata <= CLK_PATTERN;
      if (r_state == RUN) begin
        lane0_txdata <= vid_d0;
        lane1_txdata <= vid_d1;
        lane2_txdata <= vid_d2;
      end else begin
        lane0_txdata <= CTL_TOKEN;
        lane1_txdata <= CTL_TOKEN;
        lane2_txdata <= CTL_TOKEN;
      end
    end
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_hdmi_tx_lane_sequencer.sv
// Bench for hdmi_tx_lane_sequencer: directed timing scenarios plus randomized enable/lock
// traffic, all compared against a phase-duration model of the sequencer.
module tb_hdmi_tx_lane_sequencer;

  localparam int         LF          = 4;
  localparam int         SRC         = 8;
  localparam int         PC          = 16;
  localparam logic [9:0] CTL         = 10'b1101010100;
  localparam logic [9:0] CLK_PATTERN = 10'b1111100000;

  logic       pclk;
  logic       txrst;
  logic       mmcm_locked;
  logic       tx_en;
  logic [9:0] vid_d0;
  logic [9:0] vid_d1;
  logic [9:0] vid_d2;
  logic       ser_rst;
  logic [9:0] lane0_txdata;
  logic [9:0] lane1_txdata;
  logic [9:0] lane2_txdata;
  logic [9:0] clk_txdata;
  logic       link_up;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  hdmi_tx_lane_sequencer #(
    .LOCK_FILTER    (LF),
    .SER_RST_CYCLES (SRC),
    .PREAMBLE_CYCLES(PC),
    .CTL_TOKEN      (CTL)
  ) dut (
    .pclk        (pclk),
    .txrst       (txrst),
    .mmcm_locked (mmcm_locked),
    .tx_en       (tx_en),
    .vid_d0      (vid_d0),
    .vid_d1      (vid_d1),
    .vid_d2      (vid_d2),
    .ser_rst     (ser_rst),
    .lane0_txdata(lane0_txdata),
    .lane1_txdata(lane1_txdata),
    .lane2_txdata(lane2_txdata),
    .clk_txdata  (clk_txdata),
    .link_up     (link_up),
    .state_o     (state_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge, well clear of both clock edges
  task automatic applyStimulus(input bit en, input bit lk, input bit rst, input int cycles);
    repeat (cycles) begin
      @(posedge pclk);
      #2;
      tx_en       = en;
      mmcm_locked = lk;
      txrst       = rst;
      vid_d0      = 10'($urandom);
      vid_d1      = 10'($urandom);
      vid_d2      = 10'($urandom);
    end
  endtask

  // Reference model: tracks the phase, how long the synchronized lock has been high, and
  // how many cycles have been spent in the current timed phase. Outputs trail the phase by one edge.
  int         mState = 0;
  int         mRun = 0;
  int         mElapsed = 0;
  bit         mMeta = 1'b0;
  bit         mSync = 1'b0;
  bit         lockSeen;
  bit         expSerRst = 1'b1;
  bit         expLinkUp = 1'b0;
  logic [9:0] expLane0 = CTL;
  logic [9:0] expLane1 = CTL;
  logic [9:0] expLane2 = CTL;
  logic [9:0] expClk = 10'b0;

  initial forever begin
    @(posedge pclk or posedge txrst);
    if (txrst) begin
      mState    = 0;
      mRun      = 0;
      mElapsed  = 0;
      mMeta     = 1'b0;
      mSync     = 1'b0;
      expSerRst = 1'b1;
      expLinkUp = 1'b0;
      expLane0  = CTL;
      expLane1  = CTL;
      expLane2  = CTL;
      expClk    = 10'b0;
    end else begin
      lockSeen  = mSync;
      expSerRst = !(mState == 3 || mState == 4);
      expLinkUp = (mState == 4);
      expLane0  = (mState == 4) ? vid_d0 : CTL;
      expLane1  = (mState == 4) ? vid_d1 : CTL;
      expLane2  = (mState == 4) ? vid_d2 : CTL;
      expClk    = CLK_PATTERN;
      if (mState != 0 && !tx_en) begin
        mState = 0;
      end else begin
        case (mState)
          0: if (tx_en) begin mState = 1; mRun = 0; end
          1: begin
            mRun = lockSeen ? mRun + 1 : 0;
            if (mRun == LF) begin mState = 2; mElapsed = 0; end
          end
          2, 3: begin
            if (!lockSeen) begin
              mState = 1; mRun = 0;
            end else begin
              mElapsed++;
              if (mElapsed == ((mState == 2) ? SRC : PC)) begin mState++; mElapsed = 0; end
            end
          end
          4: if (!lockSeen) begin mState = 1; mRun = 0; end
          default: mState = 0;
        endcase
      end
      mSync = mMeta;
      mMeta = mmcm_locked;
    end
  end

  bit checkEnable = 1'b0;

  initial forever begin
    @(negedge pclk);
    if (checkEnable) begin
      checkOutput("state", 32'(state_o), 32'(mState));
      checkOutput("serRst", 32'(ser_rst), 32'(expSerRst));
      checkOutput("linkUp", 32'(link_up), 32'(expLinkUp));
      checkOutput("lane0", 32'(lane0_txdata), 32'(expLane0));
      checkOutput("lane1", 32'(lane1_txdata), 32'(expLane1));
      checkOutput("lane2", 32'(lane2_txdata), 32'(expLane2));
      checkOutput("clkLane", 32'(clk_txdata), 32'(expClk));
    end
  end

  int n;
  int len;
  bit done;
  bit en;
  bit lkLevel;

  initial begin
    txrst       = 1'b0;
    tx_en       = 1'b0;
    mmcm_locked = 1'b0;
    vid_d0      = 10'd0;
    vid_d1      = 10'd0;
    vid_d2      = 10'd0;
    #1 txrst = 1'b1;
    #1;
    checkOutput("rstSerRst", 32'(ser_rst), 32'd1);
    checkOutput("rstLinkUp", 32'(link_up), 32'd0);
    checkOutput("rstLane0", 32'(lane0_txdata), 32'(CTL));
    checkOutput("rstClk", 32'(clk_txdata), 32'd0);
    checkOutput("rstState", 32'(state_o), 32'd0);
    checkEnable = 1'b1;

    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 6);

    // Lock rises: 2 sync edges + 1 reaction edge, then the filter and reset phases
    @(posedge pclk);
    #2;
    mmcm_locked = 1'b1;
    vid_d0 = 10'h2AB;
    vid_d1 = 10'h0F1;
    vid_d2 = 10'h31C;
    n = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge pclk);
      #1;
      n++;
      if (!ser_rst) done = 1'b1;
    end
    checkOutput("serRstFallEdges", 32'(n), 32'(3 + LF + SRC));
    n = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge pclk);
      #1;
      n++;
      if (link_up) done = 1'b1;
    end
    checkOutput("linkUpRiseEdges", 32'(n), 32'(PC));
    checkOutput("firstRunLane0", 32'(lane0_txdata), 32'(vid_d0));
    checkOutput("firstRunLane2", 32'(lane2_txdata), 32'(vid_d2));

    applyStimulus(1'b1, 1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    @(posedge pclk);
    #1;
    checkOutput("dropLinkUp", 32'(link_up), 32'd0);
    checkOutput("dropSerRst", 32'(ser_rst), 32'd1);
    checkOutput("dropLane1", 32'(lane1_txdata), 32'(CTL));
    checkOutput("dropState", 32'(state_o), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 40);

    // Disable in the middle of the preamble
    applyStimulus(1'b1, 1'b0, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge pclk);
      #1;
      if (state_o == 3'd3) done = 1'b1;
    end
    checkOutput("reachPreamble", 32'(state_o), 32'd3);
    #1 tx_en = 1'b0;
    @(posedge pclk);
    #1;
    checkOutput("disableState", 32'(state_o), 32'd0);
    @(posedge pclk);
    #1;
    checkOutput("disableSerRst", 32'(ser_rst), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 40);

    // Asynchronous reset in the middle of a RUN cycle
    checkOutput("preRstLinkUp", 32'(link_up), 32'd1);
    @(posedge pclk);
    #2 txrst = 1'b1;
    #1;
    checkOutput("asyncRstLinkUp", 32'(link_up), 32'd0);
    checkOutput("asyncRstSerRst", 32'(ser_rst), 32'd1);
    checkOutput("asyncRstLane0", 32'(lane0_txdata), 32'(CTL));
    checkOutput("asyncRstClk", 32'(clk_txdata), 32'd0);
    checkOutput("asyncRstState", 32'(state_o), 32'd0);
    @(posedge pclk);
    #2 txrst = 1'b0;
    @(posedge pclk);
    #1;
    checkOutput("clkAfterRst", 32'(clk_txdata), 32'(CLK_PATTERN));

    lkLevel = 1'b1;
    for (int s = 0; s < 150; s++) begin
      lkLevel = ~lkLevel;
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(20, 60);
      en  = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 24) == 0) applyStimulus(en, lkLevel, 1'b1, 2);
      applyStimulus(en, lkLevel, 1'b0, len);
    end

    applyStimulus(1'b1, 1'b1, 1'b0, 3);
    @(posedge pclk);
    checkEnable = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
